// File: rtl/cic_interp_integrator_if.sv
// Sample/strobe bundle between the CIC comb, the integrator half and the modulator.
interface cic_interp_integrator_if #(
  parameter int unsigned COMB_WIDTH = 24,
  parameter int unsigned OUT_WIDTH  = 16
);
  logic signed [COMB_WIDTH-1:0] in;
  logic                         comb_en;
  logic signed [OUT_WIDTH-1:0]  out;
  logic                         out_valid;

  modport master (input in, output comb_en, output out, output out_valid);
  modport slave  (output in, input comb_en, input out, input out_valid);
endinterface

// File: rtl/cic_interp_integrator.sv
// High-rate CIC interpolator half: rate counter, zero stuffing, N integrators, output scaling.
// Define CIC_SAT_EN to saturate the output narrowing instead of wrapping.
module cic_interp_integrator #(
  parameter int unsigned COMB_WIDTH = 24,
  parameter int unsigned N          = 3,
  parameter int unsigned R          = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cic_interp_integrator_if.master bus
);

  localparam int unsigned CNT_W = $clog2(R);

  logic [CNT_W-1:0]             cnt;
  logic                         capture_c;
  logic signed [ACC_WIDTH-1:0]  x_c;
  logic signed [ACC_WIDTH-1:0]  integ [N];
  logic [N-1:0]                 vpipe;
  logic signed [ACC_WIDTH-1:0]  shifted_c;
  logic signed [OUT_WIDTH-1:0]  narrow_c;

  // The comb output is stable on the last cycle of each period; that is the capture point.
  assign capture_c = (cnt == CNT_W'(R - 1));
  assign x_c       = capture_c ? ACC_WIDTH'(bus.in) : '0;
  assign shifted_c = integ[N-1] >>> SHIFT;

`ifdef CIC_SAT_EN
  localparam int unsigned EXT_W = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [EXT_W-1:0] ext_c;
  assign ext_c = EXT_W'(shifted_c);

  // Clamp only at the output; the integrator chain itself must keep wrapping.
  always_comb begin
    narrow_c = OUT_WIDTH'(shifted_c);
    if (ext_c > OUT_MAX) begin
      narrow_c = OUT_MAX[OUT_WIDTH-1:0];
    end else if (ext_c < OUT_MIN) begin
      narrow_c = OUT_MIN[OUT_WIDTH-1:0];
    end
  end
`else
  assign narrow_c = OUT_WIDTH'(shifted_c);
`endif

  // Rate counter, integrator chain, valid tracking and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= '0;
      bus.comb_en   <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      vpipe         <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        integ[k] <= '0;
      end
    end else begin
      cnt         <= capture_c ? '0 : cnt + 1'b1;
      bus.comb_en <= (cnt == '0);
      integ[0]    <= integ[0] + x_c;
      for (int unsigned k = 1; k < N; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      // Valid marker follows the first captured sample down the chain.
      vpipe[0] <= vpipe[0] | capture_c;
      for (int unsigned k = 1; k < N; k++) begin
        vpipe[k] <= vpipe[k-1];
      end
      bus.out_valid <= vpipe[N-1];
      bus.out       <= narrow_c;
    end
  end

endmodule

// File: tb/tb_cic_interp_integrator.sv
// Scoreboard bench for cic_interp_integrator: several parameterisations share clk and rst.
module tb_cic_interp_integrator;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cic_interp_integrator_if #(.COMB_WIDTH(24), .OUT_WIDTH(16)) imp_if ();
  cic_interp_integrator_if #(.COMB_WIDTH(24), .OUT_WIDTH(16)) step_if ();
  cic_interp_integrator_if #(.COMB_WIDTH(24), .OUT_WIDTH(24)) wrap_if ();
  cic_interp_integrator_if #(.COMB_WIDTH(24), .OUT_WIDTH(16)) sat_if ();
  cic_interp_integrator_if #(.COMB_WIDTH(24), .OUT_WIDTH(16)) main_if ();

  cic_interp_integrator #(.N(3), .R(4), .SHIFT(0)) u_imp (.clk(clk), .rst(rst), .bus(imp_if));
  cic_interp_integrator #(.N(1), .R(4), .SHIFT(0)) u_step (.clk(clk), .rst(rst), .bus(step_if));
  cic_interp_integrator #(.COMB_WIDTH(24), .N(1), .R(4), .ACC_WIDTH(24), .SHIFT(0), .OUT_WIDTH(24))
    u_wrap (.clk(clk), .rst(rst), .bus(wrap_if));
  cic_interp_integrator #(.N(1), .R(4), .SHIFT(0)) u_sat (.clk(clk), .rst(rst), .bus(sat_if));
  cic_interp_integrator u_main (.clk(clk), .rst(rst), .bus(main_if));

  longint imp_q[$];
  longint step_q[$];
  longint wrap_q[$];
  longint sat_q[$];

  int imp_in  [6] = '{1, 0, 0, 0, 0, 0};
  int step_in [6] = '{5, 0, 0, 0, 0, 0};
  int wrap_in [6] = '{8388607, 1, -1, 0, 0, 0};
  int wrap_exp[6] = '{8388607, -8388608, 8388607, 8388607, 8388607, 8388607};
  int sat_in  [6] = '{40000, -80000, 40000, 0, 0, 0};
`ifdef CIC_SAT_EN
  int sat_exp [6] = '{32767, -32768, 0, 0, 0, 0};
`else
  int sat_exp [6] = '{-25536, 25536, 0, 0, 0, 0};
`endif

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      seen = imp_if.comb_en;
    end
    check("strobe_seen", longint'(seen), 1);
  endtask

  // Scoreboard monitors: one expected value per valid output cycle.
  always @(negedge clk) begin
    if (imp_if.out_valid && imp_q.size() > 0) check("imp_out", longint'(imp_if.out), imp_q.pop_front());
    if (step_if.out_valid && step_q.size() > 0) check("step_out", longint'(step_if.out), step_q.pop_front());
    if (wrap_if.out_valid && wrap_q.size() > 0) check("wrap_out", longint'(wrap_if.out), wrap_q.pop_front());
    if (sat_if.out_valid && sat_q.size() > 0) check("sat_out", longint'(sat_if.out), sat_q.pop_front());
  end

  // out_valid rise timing after the first capture (capture lands on edge 4 after release).
  initial begin : valid_timing
    @(posedge rst);
    repeat (4) @(negedge clk);
    check("step_valid_e4", longint'(step_if.out_valid), 0);
    @(negedge clk);
    check("step_valid_e5", longint'(step_if.out_valid), 1);
    @(negedge clk);
    check("imp_valid_e6", longint'(imp_if.out_valid), 0);
    @(negedge clk);
    check("imp_valid_e7", longint'(imp_if.out_valid), 1);
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int hits;
    int last;
    rst = 1'b0;
    imp_if.in  = '0;
    step_if.in = '0;
    wrap_if.in = '0;
    sat_if.in  = '0;
    main_if.in = 24'sd1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imp_out", longint'(imp_if.out), 0);
    check("rst_imp_valid", longint'(imp_if.out_valid), 0);
    check("rst_imp_comb_en", longint'(imp_if.comb_en), 0);
    check("rst_main_comb_en", longint'(main_if.comb_en), 0);
    rst = 1'b1;

    // Comb emulation: new sample right after comb_en falls, expectations pushed alongside.
    for (int p = 0; p < 6; p++) begin
      longint acc;
      wait_strobe();
      @(posedge clk);
      #1;
      imp_if.in  = 24'(imp_in[p]);
      step_if.in = 24'(step_in[p]);
      wrap_if.in = 24'(wrap_in[p]);
      sat_if.in  = 24'(sat_in[p]);
      for (int j = 1; j <= 4; j++) begin
        acc = longint'(p * 4 + j);
        imp_q.push_back(acc * (acc + 1) / 2);
        step_q.push_back(5);
        wrap_q.push_back(longint'(wrap_exp[p]));
        sat_q.push_back(longint'(sat_exp[p]));
      end
    end
    repeat (12) @(negedge clk);
    check("imp_drain", longint'(imp_q.size()), 0);
    check("step_drain", longint'(step_q.size()), 0);
    check("wrap_drain", longint'(wrap_q.size()), 0);
    check("sat_drain", longint'(sat_q.size()), 0);

    // Strobe spacing on the default R=16 instance.
    hits = 0;
    last = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (main_if.comb_en) begin
        if (last >= 0) check("strobe_gap", longint'(c - last), 16);
        last = c;
        hits++;
      end
    end
    check("strobe_count", longint'(hits), 4);

    // Mid-stream reset held for 5 cycles.
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mrst_out", longint'(main_if.out), 0);
      check("mrst_valid", longint'(main_if.out_valid), 0);
      check("mrst_comb_en", longint'(main_if.comb_en), 0);
    end
    check("mrst_imp_out", longint'(imp_if.out), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_comb_en_e1", longint'(main_if.comb_en), 1);
    check("rel_out_e1", longint'(main_if.out), 0);
    check("rel_valid_e1", longint'(main_if.out_valid), 0);
    @(negedge clk);
    check("rel_comb_en_e2", longint'(main_if.comb_en), 0);
    repeat (16) @(negedge clk);
    check("main_valid_e18", longint'(main_if.out_valid), 0);
    @(negedge clk);
    check("main_valid_e19", longint'(main_if.out_valid), 1);
    check("main_out_e19", longint'(main_if.out), 3);
    @(negedge clk);
    check("main_out_e20", longint'(main_if.out), 11);
    @(negedge clk);
    check("main_out_e21", longint'(main_if.out), 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
